sound_playout: RTL and testbench
================================

SOUND_PLAYOUT -- requirements
Module: sound_playout

Interface
REQ-001 SHALL have parameter DIV, default 250: clock cycles per output sample period (legal range 8..4095).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port frame  input  1  synchronous frame-restart pulse, the same signal that clears the upstream store's write side.
REQ-005 SHALL have port bytes_written  input  14  byte count from the upstream store since the last frame.
REQ-006 SHALL have port rdaddress  output  9  word read address into the sample buffer.
REQ-007 SHALL have port q  input  16  buffer read data; valid 2 cycles after rdaddress is driven.
REQ-008 SHALL have port sample  output  16  current signed PCM sample, held between updates.
REQ-009 SHALL have port sample_valid  output  1  one-cycle pulse, asserted when sample updates.
REQ-010 SHALL have port underrun  output  1  sticky flag, set on any sample period with no data available.

Function
REQ-011 SHALL run a tick counter from 0 to DIV-1 that wraps to 0; tick is true when the count equals DIV-1.
REQ-012 SHALL keep a 13-bit words_read counter; avail is true when bytes_written[13:1] > words_read (unsigned compare).
REQ-013 SHALL implement states IDLE, WAIT1, WAIT2 and CAPTURE; the reset state is IDLE.
REQ-014 On tick in IDLE: if avail, SHALL drive rdaddress = words_read[8:0] and go to WAIT1; otherwise SHALL set sample = 0, pulse sample_valid, set underrun, and stay in IDLE.
REQ-015 SHALL sequence WAIT1 -> WAIT2 -> CAPTURE unconditionally, holding rdaddress stable.
REQ-016 In CAPTURE, SHALL register sample = q, pulse sample_valid for one cycle, increment words_read, and return to IDLE.
REQ-017 Latency: sample_valid SHALL assert exactly 3 cycles after the tick cycle when data is available, and in the cycle after the tick when underrunning.
REQ-018 The rdaddress sequence SHALL wrap from 511 to 0, because only words_read[8:0] drives the port; avail SHALL still use the full 13 bits.
REQ-019 A tick arriving while not in IDLE SHALL be ignored; no sample is queued for it.
REQ-020 On frame, SHALL clear words_read and the tick counter, force IDLE, and suppress any in-flight sample_valid; sample and underrun SHALL hold.
REQ-021 When frame and tick occur in the same cycle, frame SHALL win and the tick SHALL be discarded.
REQ-022 A decrease of bytes_written without a frame SHALL NOT alter words_read; avail SHALL simply evaluate false.

Reset
REQ-023 Asserting reset SHALL immediately set: state IDLE, tick counter 0, words_read 0, rdaddress 0, sample 0, sample_valid 0, underrun 0.
REQ-024 Reset asserted mid-read SHALL abandon the read; no sample_valid SHALL follow the reset release.
REQ-025 underrun SHALL be cleared only by reset.

Configuration
REQ-026 With macro SOUND_PLAYOUT_PWM_EN defined, SHALL add port pwm  output  1, driven by an 8-bit free-running PWM counter.
REQ-027 pwm duty (0..255 out of 256) SHALL equal sample[15:8] XOR 8'h80, i.e. offset-binary, updated on each sample_valid.
REQ-028 pwm SHALL reset to 0.
REQ-029 Without SOUND_PLAYOUT_PWM_EN, the pwm port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 DIV=8, bytes_written=4, q model returns 16'h1234 then 16'hABCD -> rdaddress 0 then 1; sample 1234 then ABCD, each pulse 3 cycles after its tick; underrun stays 0.
REQ-031 bytes_written=0 for 3 ticks -> three sample_valid pulses with sample=0, and underrun=1 after the first.
REQ-032 Preload bytes_written=1100 (550 words) -> rdaddress walks 0..511 then 0..37; the 551st tick underruns.
REQ-033 frame pulsed during WAIT2 -> no sample_valid; next read at rdaddress 0, tick counter restarted from 0.
REQ-034 reset asserted during WAIT1 -> all outputs 0 immediately; no pulse after release.
REQ-035 With PWM_EN, sample=16'h0000 -> pwm high 128 of every 256 cycles; sample=16'h7F00 -> high 255 of 256.

Source files
------------

// File: rtl/sound_playout.sv
// sound_playout: paces PCM words out of a sample buffer at one sample every
// DIV clocks. Each sample period either fetches the next buffered word
// (three-cycle read through a 2-cycle-latency RAM port) or, when the writer
// has not supplied enough bytes, emits silence and latches a sticky underrun.
// Optional feature macro: SOUND_PLAYOUT_PWM_EN adds an 8-bit PWM output whose
// duty follows the top byte of the sample in offset-binary form.
module sound_playout #(
  parameter int DIV = 250
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame,
  input  logic [13:0]        bytes_written,
  output logic [8:0]         rdaddress,
  input  logic signed [15:0] q,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               underrun
`ifdef SOUND_PLAYOUT_PWM_EN
  ,
  output logic               pwm
`endif
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, CAPTURE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [12:0]               words_read_q, words_read_d;
  logic [8:0]                rdaddress_q, rdaddress_d;
  logic signed [DATA_W-1:0]  sample_q, sample_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      underrun_q, underrun_d;

  logic tick;
  logic avail;
  logic unused_bw_lsb;

  // Only whole 16-bit words are ever read; the odd byte is ignored.
  assign unused_bw_lsb = bytes_written[0];

  assign tick  = (tick_cnt_q == TICK_LAST);
  assign avail = (bytes_written[13:1] > words_read_q);

  // Sample-period counter; a frame restarts the period from zero.
  always_comb begin
    tick_cnt_d = tick_cnt_q + CNT_W'(1);
    if (frame || tick) begin
      tick_cnt_d = '0;
    end
  end

  // Read sequencer. The capture registers load on the edge that enters
  // CAPTURE, so sample/sample_valid become visible during CAPTURE, three
  // cycles after the tick. A frame overrides everything, including a tick
  // in the same cycle and a capture about to land.
  always_comb begin
    state_d        = state_q;
    words_read_d   = words_read_q;
    rdaddress_d    = rdaddress_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    underrun_d     = underrun_q;
    if (frame) begin
      state_d      = IDLE;
      words_read_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            if (avail) begin
              rdaddress_d = words_read_q[8:0];
              state_d     = WAIT1;
            end else begin
              sample_d       = '0;
              sample_valid_d = 1'b1;
              underrun_d     = 1'b1;
            end
          end
        end
        WAIT1: state_d = WAIT2;
        WAIT2: begin
          sample_d       = q;
          sample_valid_d = 1'b1;
          state_d        = CAPTURE;
        end
        CAPTURE: begin
          words_read_d = words_read_q + 13'd1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset abandons any read in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      words_read_q   <= '0;
      rdaddress_q    <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      words_read_q   <= words_read_d;
      rdaddress_q    <= rdaddress_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  assign rdaddress    = rdaddress_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;

`ifdef SOUND_PLAYOUT_PWM_EN
  logic [7:0] pwm_cnt_q;
  logic [7:0] duty_q;
  logic       pwm_q;

  // Signed PCM top byte to unsigned duty: flipping the sign bit maps
  // -128..127 onto 0..255 with silence at mid-scale.
  function automatic logic [7:0] offset_bin(input logic signed [DATA_W-1:0] s);
    return s[DATA_W-1 -: 8] ^ 8'h80;
  endfunction

  // Free-running PWM; duty refreshes whenever a new sample is published.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      duty_q    <= 8'h80;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (sample_valid_q) begin
        duty_q <= offset_bin(sample_q);
      end
      pwm_q <= (pwm_cnt_q < duty_q);
    end
  end

  assign pwm = pwm_q;
`endif

endmodule

// File: tb/tb_sound_playout.sv
module tb_sound_playout;
  localparam int DIV = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame = 1'b0;
  logic [13:0] bytes_written = '0;
  logic [8:0]  rdaddress;
  logic [15:0] q_r = '0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        underrun;
`ifdef SOUND_PLAYOUT_PWM_EN
  logic        pwm;
`endif

  sound_playout #(.DIV(DIV)) dut (
    .clock(clock),
    .reset(reset),
    .frame(frame),
    .bytes_written(bytes_written),
    .rdaddress(rdaddress),
    .q(q_r),
    .sample(sample),
    .sample_valid(sample_valid),
    .underrun(underrun)
`ifdef SOUND_PLAYOUT_PWM_EN
    ,
    .pwm(pwm)
`endif
  );

  always #5 clock = ~clock;

  // Sample buffer: one registered read stage, data ready two edges after
  // the address is launched.
  logic [15:0] mem [512];
  always @(posedge clock) q_r <= mem[rdaddress];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural reference: tracks the sample period by arithmetic on the
  // edge index, and schedules each expected pulse as an edge number.
  int          cyc = 0;
  int          m_phase, m_words, m_busy_until, pend_edge;
  bit          pend;
  logic [15:0] pend_val, m_sample;
  logic [8:0]  m_addr;
  logic        m_under;
  int          pulses;

  task automatic model_reset();
    m_phase = 0; m_words = 0; m_busy_until = -1; pend = 0;
    m_sample = '0; m_addr = '0; m_under = 1'b0;
  endtask

  task automatic cycle();
    bit tick_now, exp_vld;
    tick_now = (m_phase == DIV - 1);
    exp_vld = 0;
    if (frame) begin
      pend = 0; m_words = 0; m_busy_until = -1; m_phase = 0;
    end else begin
      m_phase = tick_now ? 0 : m_phase + 1;
      if (tick_now && cyc > m_busy_until) begin
        if (int'(bytes_written) / 2 > m_words) begin
          m_addr = 9'(m_words % 512);
          pend = 1; pend_edge = cyc + 2; pend_val = mem[m_addr];
          m_words++; m_busy_until = cyc + 3;
        end else begin
          m_sample = '0; m_under = 1'b1; exp_vld = 1;
        end
      end
    end
    if (pend && pend_edge == cyc) begin
      exp_vld = 1; m_sample = pend_val; pend = 0;
    end
    @(posedge clock); #1;
    cyc++;
    if (sample_valid) pulses++;
    chk("sample_valid", 32'(sample_valid), 32'(exp_vld));
    chk("sample", 32'(sample), 32'(m_sample));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("rdaddress", 32'(rdaddress), 32'(m_addr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset from wherever we are; outputs must clear at once.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_sample", 32'(sample), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_rdaddress", 32'(rdaddress), 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    pulses = 0;
  endtask

  typedef struct {
    logic [13:0] bw;
    logic [15:0] qw;
    logic [15:0] exp_sample;
    logic        exp_under;
    int          exp_k;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int first_k;
    logic [15:0] cap_s;
    logic cap_u;

    vecs[0] = '{bw: 14'd0,     qw: 16'h5555, exp_sample: 16'h0000, exp_under: 1'b1, exp_k: 8};
    vecs[1] = '{bw: 14'd1,     qw: 16'h5555, exp_sample: 16'h0000, exp_under: 1'b1, exp_k: 8};
    vecs[2] = '{bw: 14'd2,     qw: 16'h1234, exp_sample: 16'h1234, exp_under: 1'b0, exp_k: 10};
    vecs[3] = '{bw: 14'd4,     qw: 16'h8000, exp_sample: 16'h8000, exp_under: 1'b0, exp_k: 10};
    vecs[4] = '{bw: 14'd16383, qw: 16'h7FFF, exp_sample: 16'h7FFF, exp_under: 1'b0, exp_k: 10};

    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    model_reset();
    pulses = 0;

    // First sample after reset: latency, value and underrun per vector.
    foreach (vecs[v]) begin
      do_reset();
      mem[0] = vecs[v].qw;
      bytes_written = vecs[v].bw;
      first_k = 0; cap_s = '0; cap_u = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        cycle();
        if (sample_valid && first_k == 0) begin
          first_k = k; cap_s = sample; cap_u = underrun;
        end
      end
      chk("vec_latency", 32'(first_k), 32'(vecs[v].exp_k));
      chk("vec_sample", 32'(cap_s), 32'(vecs[v].exp_sample));
      chk("vec_underrun", 32'(cap_u), 32'(vecs[v].exp_under));
    end

    // Two words then a reset while the third read sits in WAIT1.
    do_reset();
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0F0F;
    bytes_written = 14'd4;
    run(10);
    chk("w1_sample", 32'(sample), 32'h1234);
    run(8);
    chk("w2_sample", 32'(sample), 32'hABCD);
    chk("w2_addr", 32'(rdaddress), 32'h1);
    chk("w2_underrun", 32'(underrun), 32'h0);
    bytes_written = 14'd6;
    run(6);
    chk("w3_addr", 32'(rdaddress), 32'h2);
    do_reset();
    run(7);
    chk("post_reset_pulses", 32'(pulses), 32'h0);

    // Continuous underrun.
    do_reset();
    bytes_written = 14'd0;
    run(7);
    chk("ur_before", 32'(underrun), 32'h0);
    run(17);
    chk("ur_pulses", 32'(pulses), 32'd3);
    chk("ur_after", 32'(underrun), 32'h1);

    // Address wrap across 550 buffered words, then underrun.
    do_reset();
    bytes_written = 14'd1100;
    run(4096);
    chk("wrap_511", 32'(rdaddress), 32'd511);
    run(8);
    chk("wrap_0", 32'(rdaddress), 32'd0);
    run(298);
    chk("wrap_37", 32'(rdaddress), 32'd37);
    chk("wrap_no_ur", 32'(underrun), 32'h0);
    run(6);
    chk("wrap_ur", 32'(underrun), 32'h1);

    // Frame during WAIT2, then frame coinciding with a tick.
    do_reset();
    bytes_written = 14'd8;
    run(16);
    chk("fr_addr1", 32'(rdaddress), 32'h1);
    run(1);
    frame = 1'b1; pulses = 0;
    cycle();
    frame = 1'b0;
    run(7);
    chk("fr_no_pulse", 32'(pulses), 32'h0);
    frame = 1'b1;
    cycle();
    frame = 1'b0;
    run(10);
    chk("fr_tick_pulses", 32'(pulses), 32'h1);
    chk("fr_restart_addr", 32'(rdaddress), 32'h0);
    chk("fr_restart_sample", 32'(sample), 32'(mem[0]));

    // Randomized frames and byte-count changes, including decreases.
    do_reset();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    bytes_written = 14'($urandom_range(0, 200));
    for (int i = 0; i < 4000; i++) begin
      frame = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) bytes_written = 14'($urandom_range(0, 1400));
      if ($urandom_range(0, 499) == 0) bytes_written = 14'h3FFF;
      cycle();
    end
    frame = 1'b0;

`ifdef SOUND_PLAYOUT_PWM_EN
    begin
      int hi;
      for (int i = 0; i < 512; i++) mem[i] = 16'h7F00;
      do_reset();
      bytes_written = 14'd2000;
      run(40);
      hi = 0;
      for (int i = 0; i < 256; i++) begin cycle(); if (pwm) hi++; end
      chk("pwm_7f00", 32'(hi), 32'd255);
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      do_reset();
      run(40);
      hi = 0;
      for (int i = 0; i < 256; i++) begin cycle(); if (pwm) hi++; end
      chk("pwm_0000", 32'(hi), 32'd128);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
